// File: rtl/rom_arbiter_if.sv
// Bus bundle between the mapper's three memory clients, the arbiter and the external memory port.
// The arbiter takes the slave view; the client/memory environment takes the master view.
interface rom_arbiter_if;
    logic [20:0] promaddr;
    logic        promreq;
    logic [7:0]  promdata;
    logic        promack;

    logic [20:0] cromaddr;
    logic        cromreq;
    logic [7:0]  cromdata;
    logic        cromack;

    logic [12:0] chrramaddr;
    logic        chrramreq;
    logic        chrramwr;
    logic [7:0]  chrramwdata;
    logic [7:0]  chrramrdata;
    logic        chrramack;

    logic        mreq;
    logic [22:0] maddr;
    logic        mwr;
    logic [7:0]  mwdata;
    logic [7:0]  mrdata;
    logic        mack;

    modport slave (
        input  promaddr, promreq, cromaddr, cromreq,
        input  chrramaddr, chrramreq, chrramwr, chrramwdata,
        input  mrdata, mack,
        output promdata, promack, cromdata, cromack, chrramrdata, chrramack,
        output mreq, maddr, mwr, mwdata
    );

    modport master (
        output promaddr, promreq, cromaddr, cromreq,
        output chrramaddr, chrramreq, chrramwr, chrramwdata,
        output mrdata, mack,
        input  promdata, promack, cromdata, cromack, chrramrdata, chrramack,
        input  mreq, maddr, mwr, mwdata
    );
endinterface

// File: rtl/rom_arbiter.sv
// Serialises PRG ROM, CHR ROM and CHR RAM clients onto one external memory port.
// CHR traffic wins by default; a starvation counter forces PRG after STARVE_MAX CHR grants.
module rom_arbiter #(
    parameter int          STARVE_MAX  = 3,
    parameter logic [22:0] CHRRAM_BASE = 23'h400000
) (
    input logic          clk,
    input logic          reset,
    rom_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    typedef enum logic [1:0] {CL_PRG, CL_CROM, CL_CHRRAM} client_t;

    localparam int            CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    state_t        state, state_nx;
    client_t       winner, winner_nx;
    logic [CW-1:0] starve_cnt, starve_nx;
    logic [22:0]   maddr_q, maddr_nx;
    logic          mwr_q, mwr_nx;
    logic [7:0]    mwdata_q, mwdata_nx;
    logic [7:0]    promdata_q, cromdata_q, chrramrdata_q;
    logic          force_prg;

    assign force_prg = bus.promreq && (starve_cnt >= STARVE_LIM);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx  = state;
        winner_nx = winner;
        maddr_nx  = maddr_q;
        mwr_nx    = mwr_q;
        mwdata_nx = mwdata_q;
        starve_nx = starve_cnt;
        case (state)
            IDLE: begin
                if (bus.promreq || bus.cromreq || bus.chrramreq) begin
                    state_nx = ISSUE;
                    if (force_prg || !(bus.cromreq || bus.chrramreq)) begin
                        winner_nx = CL_PRG;
                        maddr_nx  = {2'b00, bus.promaddr};
                        mwr_nx    = 1'b0;
                        mwdata_nx = 8'h00;
                    end else if (bus.cromreq) begin
                        winner_nx = CL_CROM;
                        maddr_nx  = {2'b01, bus.cromaddr};
                        mwr_nx    = 1'b0;
                        mwdata_nx = 8'h00;
                    end else begin
                        winner_nx = CL_CHRRAM;
                        maddr_nx  = CHRRAM_BASE + {10'd0, bus.chrramaddr};
                        mwr_nx    = bus.chrramwr;
                        mwdata_nx = bus.chrramwdata;
                    end
                    // Only a CHR grant that overtakes a waiting PRG request counts toward starvation.
                    if (winner_nx == CL_PRG || !bus.promreq)
                        starve_nx = '0;
                    else if (starve_cnt < STARVE_LIM)
                        starve_nx = starve_cnt + CW'(1);
                end
            end
            ISSUE:   if (bus.mack) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            winner     <= CL_PRG;
            starve_cnt <= '0;
            maddr_q    <= '0;
            mwr_q      <= 1'b0;
            mwdata_q   <= '0;
        end else begin
            state      <= state_nx;
            winner     <= winner_nx;
            starve_cnt <= starve_nx;
            maddr_q    <= maddr_nx;
            mwr_q      <= mwr_nx;
            mwdata_q   <= mwdata_nx;
        end
    end

    // Per-client read data holds until that client's next completed access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            promdata_q    <= '0;
            cromdata_q    <= '0;
            chrramrdata_q <= '0;
        end else if (state == ISSUE && bus.mack) begin
            case (winner)
                CL_PRG:    promdata_q    <= bus.mrdata;
                CL_CROM:   cromdata_q    <= bus.mrdata;
                CL_CHRRAM: chrramrdata_q <= bus.mrdata;
                default:   ;
            endcase
        end
    end

    assign bus.mreq        = (state == ISSUE);
    assign bus.maddr       = maddr_q;
    assign bus.mwr         = mwr_q;
    assign bus.mwdata      = mwdata_q;
    assign bus.promdata    = promdata_q;
    assign bus.cromdata    = cromdata_q;
    assign bus.chrramrdata = chrramrdata_q;
    assign bus.promack     = (state == DONE) && (winner == CL_PRG);
    assign bus.cromack     = (state == DONE) && (winner == CL_CROM);
    assign bus.chrramack   = (state == DONE) && (winner == CL_CHRRAM);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: each task drives one scenario and compares against hand-computed values.
module tb_rom_arbiter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    rom_arbiter_if bus ();

    rom_arbiter #(.STARVE_MAX(3), .CHRRAM_BASE(23'h400000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Memory responder: waits (bounded) for mreq, records the request, then returns mack k cycles later.
    // Returns at the negedge where the client ack should be visible; waited = -1 on timeout.
    task automatic mem_cycle(input int k, input logic [7:0] d, output int waited,
                             output logic [22:0] a, output logic w, output logic [7:0] wd);
        waited = -1;
        a = '0; w = 1'b0; wd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.mreq === 1'b1) begin
                waited = i;
                break;
            end
        end
        if (waited < 0) return;
        a = bus.maddr; w = bus.mwr; wd = bus.mwdata;
        repeat (k) @(negedge clk);
        bus.mrdata = d;
        bus.mack   = 1'b1;
        @(negedge clk);
        bus.mack   = 1'b0;
        bus.mrdata = 8'h00;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bus.mreq !== 1'b0) begin n_bad++; $display("FAIL reset_mreq: got %b expected 0", bus.mreq); end
        n_cmp++; if (bus.mwr !== 1'b0) begin n_bad++; $display("FAIL reset_mwr: got %b expected 0", bus.mwr); end
        n_cmp++; if (bus.maddr !== 23'h0) begin n_bad++; $display("FAIL reset_maddr: got %h expected 0", bus.maddr); end
        n_cmp++; if ({bus.promack, bus.cromack, bus.chrramack} !== 3'b000) begin n_bad++; $display("FAIL reset_acks: got %b expected 000", {bus.promack, bus.cromack, bus.chrramack}); end
        n_cmp++; if ({bus.promdata, bus.cromdata, bus.chrramrdata} !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", {bus.promdata, bus.cromdata, bus.chrramrdata}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_prg_read();
        int waited; logic [22:0] a; logic w; logic [7:0] wd;
        bus.promaddr = 21'h00_1234;
        bus.promreq  = 1'b1;
        mem_cycle(3, 8'hA5, waited, a, w, wd);
        n_cmp++; if (a !== 23'h001234) begin n_bad++; $display("FAIL prg_maddr: got %h expected 001234", a); end
        n_cmp++; if (w !== 1'b0) begin n_bad++; $display("FAIL prg_mwr: got %b expected 0", w); end
        n_cmp++; if (waited + 3 + 1 !== 5) begin n_bad++; $display("FAIL prg_latency: got %0d expected 5", waited + 4); end
        n_cmp++; if (bus.promack !== 1'b1) begin n_bad++; $display("FAIL prg_ack: got %b expected 1", bus.promack); end
        n_cmp++; if (bus.promdata !== 8'hA5) begin n_bad++; $display("FAIL prg_data: got %h expected a5", bus.promdata); end
        bus.promreq = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.promack !== 1'b0) begin n_bad++; $display("FAIL prg_ack_pulse: got %b expected 0", bus.promack); end
    endtask

    task automatic test_priority();
        int waited; logic [22:0] a; logic w; logic [7:0] wd;
        bus.cromaddr = 21'h000010;
        bus.promaddr = 21'h000ABC;
        bus.cromreq  = 1'b1;
        bus.promreq  = 1'b1;
        mem_cycle(1, 8'h11, waited, a, w, wd);
        n_cmp++; if (a !== 23'h200010) begin n_bad++; $display("FAIL prio_first_maddr: got %h expected 200010", a); end
        n_cmp++; if ({bus.cromack, bus.promack} !== 2'b10) begin n_bad++; $display("FAIL prio_first_acks: got %b expected 10", {bus.cromack, bus.promack}); end
        n_cmp++; if (bus.cromdata !== 8'h11) begin n_bad++; $display("FAIL prio_crom_data: got %h expected 11", bus.cromdata); end
        bus.cromreq = 1'b0;
        mem_cycle(1, 8'h22, waited, a, w, wd);
        n_cmp++; if (a !== 23'h000ABC) begin n_bad++; $display("FAIL prio_second_maddr: got %h expected 000abc", a); end
        n_cmp++; if (waited !== 2) begin n_bad++; $display("FAIL prio_second_wait: got %0d expected 2", waited); end
        n_cmp++; if ({bus.cromack, bus.promack} !== 2'b01) begin n_bad++; $display("FAIL prio_second_acks: got %b expected 01", {bus.cromack, bus.promack}); end
        n_cmp++; if (bus.promdata !== 8'h22) begin n_bad++; $display("FAIL prio_prg_data: got %h expected 22", bus.promdata); end
        bus.promreq = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.cromack, bus.promack} !== 2'b00) begin n_bad++; $display("FAIL prio_acks_after: got %b expected 00", {bus.cromack, bus.promack}); end
    endtask

    task automatic test_chrram();
        int waited; logic [22:0] a; logic w; logic [7:0] wd;
        bus.chrramaddr  = 13'h1FFF;
        bus.chrramwr    = 1'b1;
        bus.chrramwdata = 8'h3C;
        bus.chrramreq   = 1'b1;
        mem_cycle(2, 8'h00, waited, a, w, wd);
        n_cmp++; if (a !== 23'h401FFF) begin n_bad++; $display("FAIL chrram_wr_maddr: got %h expected 401fff", a); end
        n_cmp++; if (w !== 1'b1) begin n_bad++; $display("FAIL chrram_wr_mwr: got %b expected 1", w); end
        n_cmp++; if (wd !== 8'h3C) begin n_bad++; $display("FAIL chrram_wr_mwdata: got %h expected 3c", wd); end
        n_cmp++; if (bus.chrramack !== 1'b1) begin n_bad++; $display("FAIL chrram_wr_ack: got %b expected 1", bus.chrramack); end
        bus.chrramreq = 1'b0;
        @(negedge clk);
        bus.chrramwr  = 1'b0;
        bus.chrramreq = 1'b1;
        mem_cycle(0, 8'h3C, waited, a, w, wd);
        n_cmp++; if (a !== 23'h401FFF || w !== 1'b0) begin n_bad++; $display("FAIL chrram_rd_req: got %h/%b expected 401fff/0", a, w); end
        n_cmp++; if (bus.chrramack !== 1'b1) begin n_bad++; $display("FAIL chrram_rd_ack: got %b expected 1", bus.chrramack); end
        n_cmp++; if (bus.chrramrdata !== 8'h3C) begin n_bad++; $display("FAIL chrram_rd_data: got %h expected 3c", bus.chrramrdata); end
        bus.chrramreq = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        int waited; logic [22:0] a; logic w; logic [7:0] wd;
        bus.cromaddr = 21'h1F_0001;
        bus.cromreq  = 1'b1;
        mem_cycle(0, 8'hC3, waited, a, w, wd);
        n_cmp++; if (waited + 0 + 1 !== 2) begin n_bad++; $display("FAIL zw_latency: got %0d expected 2", waited + 1); end
        n_cmp++; if (bus.mreq !== 1'b0) begin n_bad++; $display("FAIL zw_mreq_one_cycle: got %b expected 0", bus.mreq); end
        n_cmp++; if (bus.cromack !== 1'b1 || bus.cromdata !== 8'hC3) begin n_bad++; $display("FAIL zw_ack_data: got %b/%h expected 1/c3", bus.cromack, bus.cromdata); end
        n_cmp++; if (a !== 23'h3F0001) begin n_bad++; $display("FAIL zw_maddr: got %h expected 3f0001", a); end
        bus.cromreq = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int waited; logic [22:0] a; logic w; logic [7:0] wd;
        bus.promaddr = 21'h1F_FFFF;
        bus.promreq  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.cromaddr = 21'(i);
            bus.cromreq  = 1'b1;
            mem_cycle(0, 8'(i), waited, a, w, wd);
            n_cmp++; if (a !== {2'b01, 21'(i)} || bus.cromack !== 1'b1) begin n_bad++; $display("FAIL starve_crom_%0d: got %h/%b expected %h/1", i, a, bus.cromack, {2'b01, 21'(i)}); end
            bus.cromreq = 1'b0;
            @(negedge clk);
        end
        bus.cromaddr = 21'd3;
        bus.cromreq  = 1'b1;
        mem_cycle(0, 8'h5A, waited, a, w, wd);
        n_cmp++; if (a !== 23'h1FFFFF) begin n_bad++; $display("FAIL starve_forced_prg: got %h expected 1fffff", a); end
        n_cmp++; if ({bus.promack, bus.cromack} !== 2'b10 || bus.promdata !== 8'h5A) begin n_bad++; $display("FAIL starve_prg_ack: got %b/%h expected 10/5a", {bus.promack, bus.cromack}, bus.promdata); end
        bus.promreq = 1'b0;
        @(negedge clk);
        bus.promreq = 1'b1;
        mem_cycle(0, 8'h66, waited, a, w, wd);
        n_cmp++; if (a !== 23'h200003 || bus.cromack !== 1'b1) begin n_bad++; $display("FAIL starve_cleared: got %h/%b expected 200003/1", a, bus.cromack); end
        bus.cromreq = 1'b0;
        mem_cycle(0, 8'h77, waited, a, w, wd);
        n_cmp++; if (a !== 23'h1FFFFF || bus.promack !== 1'b1) begin n_bad++; $display("FAIL starve_final_prg: got %h/%b expected 1fffff/1", a, bus.promack); end
        bus.promreq = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_issue();
        int waited; logic [22:0] a; logic w; logic [7:0] wd;
        bus.promaddr    = 21'h00_0042;
        bus.promreq     = 1'b1;
        bus.chrramaddr  = 13'h0005;
        bus.chrramwr    = 1'b1;
        bus.chrramwdata = 8'h99;
        bus.chrramreq   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.mreq !== 1'b1 || bus.mwr !== 1'b1) begin n_bad++; $display("FAIL rst_issue_entry: got %b/%b expected 1/1", bus.mreq, bus.mwr); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.mreq !== 1'b0 || bus.mwr !== 1'b0) begin n_bad++; $display("FAIL rst_async_mreq_mwr: got %b/%b expected 0/0", bus.mreq, bus.mwr); end
        n_cmp++; if ({bus.promack, bus.cromack, bus.chrramack} !== 3'b000) begin n_bad++; $display("FAIL rst_async_acks: got %b expected 000", {bus.promack, bus.cromack, bus.chrramack}); end
        n_cmp++; if (bus.maddr !== 23'h0 || bus.chrramrdata !== 8'h00 || bus.promdata !== 8'h00) begin n_bad++; $display("FAIL rst_async_regs: got %h/%h/%h expected 0/0/0", bus.maddr, bus.chrramrdata, bus.promdata); end
        n_cmp++; if (dut.starve_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_starve_cnt: got %0d expected 0", dut.starve_cnt); end
        @(negedge clk);
        reset = 1'b0;
        mem_cycle(1, 8'h00, waited, a, w, wd);
        n_cmp++; if (waited !== 1 || a !== 23'h400005 || w !== 1'b1 || wd !== 8'h99) begin n_bad++; $display("FAIL rst_regrant: got %0d/%h/%b/%h expected 1/400005/1/99", waited, a, w, wd); end
        n_cmp++; if (bus.chrramack !== 1'b1) begin n_bad++; $display("FAIL rst_regrant_ack: got %b expected 1", bus.chrramack); end
        bus.chrramreq = 1'b0;
        mem_cycle(0, 8'hE1, waited, a, w, wd);
        n_cmp++; if (a !== 23'h000042 || bus.promack !== 1'b1 || bus.promdata !== 8'hE1) begin n_bad++; $display("FAIL rst_prg_after: got %h/%b/%h expected 000042/1/e1", a, bus.promack, bus.promdata); end
        bus.promreq = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.promaddr = '0;   bus.promreq = 1'b0;
        bus.cromaddr = '0;   bus.cromreq = 1'b0;
        bus.chrramaddr = '0; bus.chrramreq = 1'b0;
        bus.chrramwr = 1'b0; bus.chrramwdata = '0;
        bus.mrdata = '0;     bus.mack = 1'b0;
        @(negedge clk);
        test_reset();
        test_prg_read();
        test_priority();
        test_chrram();
        test_zero_wait();
        test_starvation();
        test_reset_in_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
